// File: rtl/sync_counter.sv
// sync_counter: parameterised synchronous binary up-counter.
// Priority at each rising edge: reset > clear > load > enable > hold.
// Optional wrap flag on ovf_o is built when COUNTER_OVERFLOW_FLAG_EN is defined;
// otherwise ovf_o is tied low and no flag register exists.
module sync_counter #(
  parameter int unsigned COUNTER_WIDTH = 8,
  parameter int unsigned RESET_VAL     = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     load_i,
  input  logic [COUNTER_WIDTH-1:0] load_val_i,
  input  logic                     en_i,
  output logic [COUNTER_WIDTH-1:0] count_o,
  output logic                     ovf_o
);

  // RESET_VAL is deliberately truncated to the register width
  localparam logic [COUNTER_WIDTH-1:0] RST_V = COUNTER_WIDTH'(RESET_VAL);

  logic [COUNTER_WIDTH-1:0] cnt_q;
  logic [COUNTER_WIDTH-1:0] cnt_d;
  logic                     inc_win;

  // increment only happens when enable is the winning action this edge
  assign inc_win = en_i & ~clr_i & ~load_i;

  // next-count selection by priority (reset handled in the register)
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = RST_V;
    else if (load_i) cnt_d = load_val_i;
    else if (en_i)   cnt_d = cnt_q + 1'b1;
  end

  // count register, drives count_o directly
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= RST_V;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

`ifdef COUNTER_OVERFLOW_FLAG_EN
  logic ovf_q;

  // one-cycle pulse aligned with count_o showing 0 after an all-ones increment
  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= inc_win & (&cnt_q);
  end

  assign ovf_o = ovf_q;
`else
  logic unused_inc_win;
  assign unused_inc_win = inc_win;
  assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_sync_counter.sv
// Bench for sync_counter: table-driven vectors, test-plan sequences and
// randomized stimulus against an arithmetic reference model. Two instances:
// default (8-bit, reset 0) and a 4-bit one with reset value 5.
module tb_sync_counter;

`ifdef COUNTER_OVERFLOW_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0, clr = 1'b0, load = 1'b0, en = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] cnt8;
  logic [3:0] cnt4;
  logic       ovf8, ovf4;

  int total  = 0;
  int passed = 0;

  // reference state: plain integers, modular arithmetic
  int m8 = 0, m4 = 5;
  bit o8 = 0, o4 = 0;

  always #5 clk = ~clk;

  sync_counter #(.COUNTER_WIDTH(8), .RESET_VAL(0)) u_c8 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load),
    .load_val_i(load_val), .en_i(en), .count_o(cnt8), .ovf_o(ovf8)
  );

  sync_counter #(.COUNTER_WIDTH(4), .RESET_VAL(5)) u_c4 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load),
    .load_val_i(load_val[3:0]), .en_i(en), .count_o(cnt4), .ovf_o(ovf4)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // apply one cycle of inputs, advance the model, compare both instances
  task automatic step(input bit r, input bit c, input bit l,
                      input logic [7:0] lv, input bit e);
    int width_mod8, width_mod4;
    width_mod8 = 256;
    width_mod4 = 16;
    rst = r; clr = c; load = l; load_val = lv; en = e;
    @(posedge clk);
    if (r || c)  begin m8 = 0; m4 = 5; o8 = 0; o4 = 0; end
    else if (l)  begin m8 = int'(lv); m4 = int'(lv) % width_mod4; o8 = 0; o4 = 0; end
    else if (e)  begin
      o8 = (m8 == width_mod8 - 1);
      o4 = (m4 == width_mod4 - 1);
      m8 = (m8 + 1) % width_mod8;
      m4 = (m4 + 1) % width_mod4;
    end
    else begin o8 = 0; o4 = 0; end
    #1;
    check("cnt8", int'(cnt8), m8);
    check("ovf8", int'(ovf8), OVF_EN ? int'(o8) : 0);
    check("cnt4", int'(cnt4), m4);
    check("ovf4", int'(ovf4), OVF_EN ? int'(o4) : 0);
  endtask

  typedef struct {
    bit rst, clr, ld;
    logic [7:0] lv;
    bit en;
    logic [7:0] cnt;
    bit ovf;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // {rst, clr, load, load_val, en, expected count, expected ovf (flag build)}
    tbl[0]  = '{1, 0, 0, 8'h00, 0, 8'h00, 0}; // reset
    tbl[1]  = '{0, 0, 1, 8'hFF, 1, 8'hFF, 0}; // load beats enable
    tbl[2]  = '{0, 0, 0, 8'h00, 1, 8'h00, 1}; // wrap pulse
    tbl[3]  = '{0, 0, 0, 8'h00, 1, 8'h01, 0}; // pulse lasts one cycle
    tbl[4]  = '{0, 0, 1, 8'h00, 1, 8'h00, 0}; // load of 0: no pulse
    tbl[5]  = '{0, 1, 1, 8'hAA, 0, 8'h00, 0}; // clear beats load
    tbl[6]  = '{0, 0, 1, 8'h7F, 0, 8'h7F, 0};
    tbl[7]  = '{0, 0, 1, 8'h7F, 1, 8'h7F, 0}; // load held
    tbl[8]  = '{0, 0, 0, 8'h00, 1, 8'h80, 0};
    tbl[9]  = '{0, 0, 0, 8'h00, 0, 8'h80, 0}; // hold
    tbl[10] = '{0, 0, 1, 8'hFF, 0, 8'hFF, 0};
    tbl[11] = '{0, 1, 0, 8'h00, 1, 8'h00, 0}; // clear from all-ones: no pulse
    tbl[12] = '{0, 0, 1, 8'hFF, 0, 8'hFF, 0};
    tbl[13] = '{1, 0, 0, 8'h00, 1, 8'h00, 0}; // reset from all-ones: no pulse

    @(negedge clk);

    // table-driven vectors
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].en);
      check($sformatf("tbl%0d_cnt", i), int'(cnt8), int'(tbl[i].cnt));
      check($sformatf("tbl%0d_ovf", i), int'(ovf8), OVF_EN ? int'(tbl[i].ovf) : 0);
    end

    // reset held 3 cycles with enable high
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 8'h00, 1);
      check("rst_hold_cnt", int'(cnt8), 0);
      check("rst_hold_ovf", int'(ovf8), 0);
    end
    step(0, 0, 0, 8'h00, 1);
    check("rst_release", int'(cnt8), 1);

    // count 0 -> 37 then idle
    step(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 37; i++) step(0, 0, 0, 8'h00, 1);
    check("count37", int'(cnt8), 37);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 8'h00, 0);
      check("idle37", int'(cnt8), 37);
    end

    // clear with enable, then 10 edges
    step(0, 1, 0, 8'h00, 1);
    check("clr_en", int'(cnt8), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 8'h00, 1);
    check("after_clr10", int'(cnt8), 10);

    // load FE with enable, then wrap
    step(0, 0, 1, 8'hFE, 1);
    check("load_fe", int'(cnt8), 8'hFE);
    step(0, 0, 0, 8'h00, 1);
    check("inc_ff", int'(cnt8), 8'hFF);
    check("ff_no_ovf", int'(ovf8), 0);
    step(0, 0, 0, 8'h00, 1);
    check("wrap_00", int'(cnt8), 0);
    check("wrap_ovf", int'(ovf8), OVF_EN ? 1 : 0);
    step(0, 0, 0, 8'h00, 1);
    check("ovf_drop", int'(ovf8), 0);

    // reset mid-count at 20
    step(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 8'h00, 1);
    check("at20", int'(cnt8), 20);
    step(1, 0, 0, 8'h00, 1);
    check("midrst", int'(cnt8), 0);
    step(0, 0, 0, 8'h00, 1);
    check("midrst_next", int'(cnt8), 1);

    // 4-bit instance, reset value 5
    step(1, 0, 0, 8'h00, 0);
    check("w4_reset", int'(cnt4), 5);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 8'h00, 1);
    check("w4_wrap", int'(cnt4), 0);
    check("w4_ovf", int'(ovf4), OVF_EN ? 1 : 0);
    step(0, 1, 0, 8'h00, 0);
    check("w4_clr", int'(cnt4), 5);

    // randomized stimulus against the model
    for (int i = 0; i < 400; i++) begin
      bit r, c, l, e;
      logic [7:0] lv;
      r  = ($urandom_range(0, 49) == 0);
      c  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 14) == 0);
      e  = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 1) == 0) ? 8'(8'hF0 + $urandom_range(0, 15))
                                       : 8'($urandom_range(0, 255));
      step(r, c, l, lv, e);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
